// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for clk_ratio_monitor: FSM state enum, counter
// width derivation and the high-time acceptance rule.
package clk_mon_pkg;

  typedef enum logic {
    ARM  = 1'b0,
    MEAS = 1'b1
  } clk_mon_state_e;

  function automatic int cnt_width(input int max_period);
    return $clog2(max_period + 1);
  endfunction

  // Odd divisors put the falling edge mid-cycle, so either rounding is accepted.
  function automatic logic duty_ok(input int unsigned high, input int unsigned divisor);
    return (high == divisor / 2) || (high == (divisor + 1) / 2);
  endfunction

endpackage

// File: rtl/clk_ratio_monitor_sync_2ff.sv
// Two-flop synchronizer (1 bit) with synchronous active-high reset to 0,
// used by clk_ratio_monitor when CLK_MON_SYNC_EN is defined.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/clk_ratio_monitor.sv
// Divided-clock checker: measures period/high time of i_mon_clk in i_clk cycles,
// reports lock, error and timeout. Macro CLK_MON_SYNC_EN adds a 2-flop input synchronizer.
module clk_ratio_monitor
  import clk_mon_pkg::*;
#(
  parameter int DIVISOR    = 4,
  parameter int LOCK_COUNT = 4,
  parameter int MAX_PERIOD = 255,
  parameter int CNT_W      = cnt_width(MAX_PERIOD)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_mon_clk,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_meas_valid,
  output logic             o_lock,
  output logic             o_period_err,
  output logic             o_duty_err,
  output logic             o_timeout
);

  localparam int                GOOD_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  DIV_CNT   = CNT_W'(DIVISOR);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0]  ONE_CNT   = CNT_W'(1);
  localparam logic [GOOD_W-1:0] LOCK_GOOD = GOOD_W'(LOCK_COUNT);

  logic s;

`ifdef CLK_MON_SYNC_EN
  sync_2ff u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_mon_clk),
    .o_q   (s)
  );
`else
  logic samp_d, samp_q;

  always_comb samp_d = i_mon_clk;

  always_ff @(posedge i_clk) begin
    if (i_rst) samp_q <= 1'b0;
    else       samp_q <= samp_d;
  end

  assign s = samp_q;
`endif

  logic s_dly_d, s_dly_q;
  logic rise;

  always_comb s_dly_d = s;
  assign rise = s & ~s_dly_q;

  clk_mon_state_e   state_d, state_q;
  logic [CNT_W-1:0] per_cnt_d, per_cnt_q;
  logic [CNT_W-1:0] high_cnt_d, high_cnt_q;
  logic [CNT_W-1:0] period_d, period_q;
  logic [CNT_W-1:0] high_d, high_q;
  logic [GOOD_W-1:0] good_cnt_d, good_cnt_q;
  logic             meas_valid_d, meas_valid_q;
  logic             period_err_d, period_err_q;
  logic             duty_err_d, duty_err_q;
  logic             timeout_d, timeout_q;
  logic             per_bad, duty_bad;

  always_comb begin
    state_d      = state_q;
    per_cnt_d    = per_cnt_q;
    high_cnt_d   = high_cnt_q;
    period_d     = period_q;
    high_d       = high_q;
    good_cnt_d   = good_cnt_q;
    meas_valid_d = 1'b0;
    period_err_d = 1'b0;
    duty_err_d   = 1'b0;
    timeout_d    = timeout_q;
    per_bad      = (per_cnt_q != DIV_CNT);
    duty_bad     = !duty_ok(32'(high_cnt_q), DIVISOR);

    case (state_q)
      ARM: begin
        per_cnt_d  = '0;
        high_cnt_d = '0;
        // The arming rise starts a measurement but never reports one.
        if (rise) begin
          state_d    = MEAS;
          per_cnt_d  = ONE_CNT;
          high_cnt_d = ONE_CNT;
          timeout_d  = 1'b0;
        end
      end
      MEAS: begin
        if (rise) begin
          period_d     = per_cnt_q;
          high_d       = high_cnt_q;
          meas_valid_d = 1'b1;
          period_err_d = per_bad;
          duty_err_d   = duty_bad;
          if (per_bad || duty_bad)        good_cnt_d = '0;
          else if (good_cnt_q != LOCK_GOOD) good_cnt_d = good_cnt_q + GOOD_W'(1);
          per_cnt_d    = ONE_CNT;
          high_cnt_d   = ONE_CNT;
        end else if (per_cnt_q == MAX_CNT) begin
          timeout_d  = 1'b1;
          good_cnt_d = '0;
          state_d    = ARM;
          per_cnt_d  = '0;
          high_cnt_d = '0;
        end else begin
          // per_cnt_q < MAX_CNT here, so the increment cannot pass saturation.
          per_cnt_d  = per_cnt_q + ONE_CNT;
          high_cnt_d = high_cnt_q + {{(CNT_W-1){1'b0}}, s};
        end
      end
      default: state_d = ARM;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s_dly_q      <= 1'b0;
      state_q      <= ARM;
      per_cnt_q    <= '0;
      high_cnt_q   <= '0;
      period_q     <= '0;
      high_q       <= '0;
      good_cnt_q   <= '0;
      meas_valid_q <= 1'b0;
      period_err_q <= 1'b0;
      duty_err_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      s_dly_q      <= s_dly_d;
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      high_cnt_q   <= high_cnt_d;
      period_q     <= period_d;
      high_q       <= high_d;
      good_cnt_q   <= good_cnt_d;
      meas_valid_q <= meas_valid_d;
      period_err_q <= period_err_d;
      duty_err_q   <= duty_err_d;
      timeout_q    <= timeout_d;
    end
  end

  assign o_period     = period_q;
  assign o_high       = high_q;
  assign o_meas_valid = meas_valid_q;
  assign o_lock       = (good_cnt_q == LOCK_GOOD);
  assign o_period_err = period_err_q;
  assign o_duty_err   = duty_err_q;
  assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Bench for clk_ratio_monitor: a /4 instance and a /5 instance (MAX_PERIOD=20),
// a queue-based reference model compared every cycle, plus hand-computed checks.
module tb_clk_ratio_monitor;

  localparam int CW   = $clog2(21);
  localparam int MAXP = 20;
  localparam int LOCK = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4, rst5, mon4, mon5;
  logic [CW-1:0] per4, high4, per5, high5;
  logic vld4, lock4, perr4, derr4, to4;
  logic vld5, lock5, perr5, derr5, to5;

  clk_ratio_monitor #(.DIVISOR(4), .LOCK_COUNT(LOCK), .MAX_PERIOD(MAXP)) u4 (
    .i_clk(clk), .i_rst(rst4), .i_mon_clk(mon4),
    .o_period(per4), .o_high(high4), .o_meas_valid(vld4), .o_lock(lock4),
    .o_period_err(perr4), .o_duty_err(derr4), .o_timeout(to4)
  );

  clk_ratio_monitor #(.DIVISOR(5), .LOCK_COUNT(LOCK), .MAX_PERIOD(MAXP)) u5 (
    .i_clk(clk), .i_rst(rst5), .i_mon_clk(mon5),
    .o_period(per5), .o_high(high5), .o_meas_valid(vld5), .o_lock(lock5),
    .o_period_err(perr5), .o_duty_err(derr5), .o_timeout(to5)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sampled history since the last rise held in a queue;
  // period is its length, high time is its sum.
  int m_div [2] = '{4, 5};
  bit m_armed [2];
  bit m_cur [2], m_prev [2], m_mid [2];
  bit m_q [2][$];
  int m_good [2];
  int e_period [2], e_high [2];
  bit e_valid [2], e_perr [2], e_derr [2], e_to [2], e_lock [2];

  task automatic model_step(input int id, input bit rst, input bit din);
    int  sum;
    int  len;
    bit  rise;
    bit  ok_p, ok_d;
    if (rst) begin
      m_armed[id] = 0; m_cur[id] = 0; m_prev[id] = 0; m_mid[id] = 0;
      m_q[id].delete(); m_good[id] = 0;
      e_period[id] = 0; e_high[id] = 0;
      e_valid[id] = 0; e_perr[id] = 0; e_derr[id] = 0; e_to[id] = 0;
    end else begin
      rise = m_cur[id] && !m_prev[id];
      e_valid[id] = 0; e_perr[id] = 0; e_derr[id] = 0;
      if (!m_armed[id]) begin
        if (rise) begin
          m_armed[id] = 1;
          e_to[id] = 0;
          m_q[id].delete();
          m_q[id].push_back(m_cur[id]);
        end
      end else if (rise) begin
        sum = 0;
        len = m_q[id].size();
        for (int k = 0; k < len; k++) sum += int'(m_q[id][k]);
        ok_p = (len == m_div[id]);
        ok_d = ((2 * sum - m_div[id]) <= 1) && ((m_div[id] - 2 * sum) <= 1);
        e_period[id] = len;
        e_high[id]   = sum;
        e_valid[id]  = 1;
        e_perr[id]   = !ok_p;
        e_derr[id]   = !ok_d;
        if (ok_p && ok_d) m_good[id] = (m_good[id] < LOCK) ? m_good[id] + 1 : LOCK;
        else              m_good[id] = 0;
        m_q[id].delete();
        m_q[id].push_back(m_cur[id]);
      end else if (m_q[id].size() == MAXP) begin
        e_to[id] = 1;
        m_armed[id] = 0;
        m_good[id] = 0;
        m_q[id].delete();
      end else begin
        m_q[id].push_back(m_cur[id]);
      end
      m_prev[id] = m_cur[id];
`ifdef CLK_MON_SYNC_EN
      m_cur[id] = m_mid[id];
      m_mid[id] = din;
`else
      m_cur[id] = din;
`endif
    end
    e_lock[id] = (m_good[id] == LOCK);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step(0, rst4, mon4);
      model_step(1, rst5, mon5);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("u4 o_period",     int'(per4),  e_period[0]);
        check("u4 o_high",       int'(high4), e_high[0]);
        check("u4 o_meas_valid", int'(vld4),  int'(e_valid[0]));
        check("u4 o_lock",       int'(lock4), int'(e_lock[0]));
        check("u4 o_period_err", int'(perr4), int'(e_perr[0]));
        check("u4 o_duty_err",   int'(derr4), int'(e_derr[0]));
        check("u4 o_timeout",    int'(to4),   int'(e_to[0]));
        check("u5 o_period",     int'(per5),  e_period[1]);
        check("u5 o_high",       int'(high5), e_high[1]);
        check("u5 o_meas_valid", int'(vld5),  int'(e_valid[1]));
        check("u5 o_lock",       int'(lock5), int'(e_lock[1]));
        check("u5 o_period_err", int'(perr5), int'(e_perr[1]));
        check("u5 o_duty_err",   int'(derr5), int'(e_derr[1]));
        check("u5 o_timeout",    int'(to5),   int'(e_to[1]));
      end
    end
  end

  typedef struct {
    int period;
    int high;
    bit perr;
    bit derr;
    bit lock;
  } meas_t;

  meas_t log4[$];
  meas_t log5[$];

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && vld4 === 1'b1) log4.push_back('{int'(per4), int'(high4), perr4, derr4, lock4});
      if (chk_en && vld5 === 1'b1) log5.push_back('{int'(per5), int'(high5), perr5, derr5, lock5});
    end
  end

  task automatic chk_log(input int id, input int idx, input int p, input int h,
                         input bit pe, input bit de, input bit lk);
    meas_t m;
    int    sz;
    sz = (id == 0) ? log4.size() : log5.size();
    if (idx >= sz) begin
      check($sformatf("u%0d log[%0d] present", id == 0 ? 4 : 5, idx), sz, idx + 1);
    end else begin
      m = (id == 0) ? log4[idx] : log5[idx];
      check($sformatf("u%0d log[%0d] period", id == 0 ? 4 : 5, idx), m.period, p);
      check($sformatf("u%0d log[%0d] high",   id == 0 ? 4 : 5, idx), m.high, h);
      check($sformatf("u%0d log[%0d] perr",   id == 0 ? 4 : 5, idx), int'(m.perr), int'(pe));
      check($sformatf("u%0d log[%0d] derr",   id == 0 ? 4 : 5, idx), int'(m.derr), int'(de));
      check($sformatf("u%0d log[%0d] lock",   id == 0 ? 4 : 5, idx), int'(m.lock), int'(lk));
    end
  endtask

  task automatic drive4(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < p; c++) begin
        mon4 = (c < h);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    rst4 = 1'b1; rst5 = 1'b1; mon4 = 1'b0; mon5 = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset o_period",     int'(per4),  0);
    check("reset o_high",       int'(high4), 0);
    check("reset o_meas_valid", int'(vld4),  0);
    check("reset o_lock",       int'(lock4), 0);
    check("reset o_period_err", int'(perr4), 0);
    check("reset o_duty_err",   int'(derr4), 0);
    check("reset o_timeout",    int'(to4),   0);
    check("reset u5 o_lock",    int'(lock5), 0);
    rst4 = 1'b0; rst5 = 1'b0;

    fork
      begin
        drive4(4, 2, 7);                 // nominal
        drive4(6, 3, 3);                 // ratio change
        mon4 = 1'b0;
        repeat (3) @(negedge clk);
        check("ratio live o_period", int'(per4), 6);
        check("ratio live o_lock",   int'(lock4), 0);
        drive4(4, 2, 5);                 // relock
        drive4(4, 1, 1);                 // duty glitch
        drive4(4, 2, 5);
        mon4 = 1'b0;                     // stall -> timeout
        repeat (25) @(negedge clk);
        check("timeout o_timeout", int'(to4), 1);
        check("timeout o_lock",    int'(lock4), 0);
        drive4(4, 2, 6);                 // resume, relock
        fork
          drive4(4, 2, 5);
          begin
            repeat (6) @(negedge clk);
            rst4 = 1'b1;
            @(negedge clk);
            check("midreset o_period",     int'(per4),  0);
            check("midreset o_high",       int'(high4), 0);
            check("midreset o_lock",       int'(lock4), 0);
            check("midreset o_meas_valid", int'(vld4),  0);
            rst4 = 1'b0;
          end
        join
        mon4 = 1'b0;
        repeat (3) @(negedge clk);
      end
      begin
        #2;
        for (int i = 0; i < 8; i++) begin mon5 = 1'b1; #25; mon5 = 1'b0; #25; end
        for (int i = 0; i < 8; i++) begin mon5 = 1'b1; #15; mon5 = 1'b0; #35; end
      end
    join

    check("u4 measurement count", log4.size(), 29);
    chk_log(0, 0,  4, 2, 0, 0, 0);
    chk_log(0, 2,  4, 2, 0, 0, 0);
    chk_log(0, 3,  4, 2, 0, 0, 1);
    chk_log(0, 6,  4, 2, 0, 0, 1);
    chk_log(0, 7,  6, 3, 1, 1, 0);
    chk_log(0, 8,  6, 3, 1, 1, 0);
    chk_log(0, 9,  9, 3, 1, 1, 0);
    chk_log(0, 12, 4, 2, 0, 0, 0);
    chk_log(0, 13, 4, 2, 0, 0, 1);
    chk_log(0, 15, 4, 1, 0, 1, 0);
    chk_log(0, 18, 4, 2, 0, 0, 0);
    chk_log(0, 19, 4, 2, 0, 0, 1);
    chk_log(0, 20, 4, 2, 0, 0, 0);
    chk_log(0, 23, 4, 2, 0, 0, 1);
    chk_log(0, 26, 4, 2, 0, 0, 1);
    chk_log(0, 27, 4, 2, 0, 0, 0);

    check("u5 measurement count", log5.size(), 15);
    chk_log(1, 0,  5, 3, 0, 0, 0);
    chk_log(1, 3,  5, 3, 0, 0, 1);
    chk_log(1, 8,  5, 2, 0, 0, 1);
    chk_log(1, 14, 5, 2, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
